heap_array_streamer: RTL and testbench
======================================

Name: heap_array_streamer

Overview:
Reads a heap array back out as a valid/ready element stream. It is the read-side counterpart of the array-building instructions, which write elements and track sizes. Given an array handle, it fetches the array's recorded size from the arraySizes RAM, then streams the elements from the heap RAM in index order into a 2-entry output FIFO. Used by the test harness and the out channel to dump array contents.

Parameters:
MemoryElementWidth, 12, width of heap elements, sizes and handles
NArea, 10, heap words per array; element i of array a lives at a*NArea+i
NArrays, 2000, number of array handles
NHeap, 10000, heap depth
HeapAddrWidth, 14, heap address width; must satisfy 2**HeapAddrWidth >= NHeap

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
array  input  MemoryElementWidth  array handle; sampled with start
sizeRe  output  1  arraySizes read enable
sizeAddr  output  MemoryElementWidth  arraySizes read address
sizeData  input  MemoryElementWidth  size word, valid the cycle after sizeRe
heapRe  output  1  heap read enable
heapAddr  output  HeapAddrWidth  heap read address
heapData  input  MemoryElementWidth  heap word, valid the cycle after heapRe
outValid  output  1  FIFO head valid
outReady  input  1  consumer accepts the head this cycle
outData  output  MemoryElementWidth  element value
outLast  output  1  head is the final element of the array
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle pulse at the end of each request
sizeError  output  1  sticky; size was clamped or handle was out of range; cleared by the next accepted start

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; FIFO flushed.
  - All outputs go to 0 at that edge.
  - Reset mid-stream abandons the request with no done pulse.
- Handshake: a transfer occurs when outValid && outReady.
  - outData and outLast hold stable while outValid && !outReady.
- States: IDLE -> SIZE -> SIZEWAIT -> STREAM -> DRAIN -> IDLE.
- IDLE: start==1 latches array and clears sizeError.
  - If array >= NArrays: sizeError=1, done pulses the next cycle, no memory reads, return to IDLE.
  - Start while busy is ignored.
- SIZE: sizeRe=1, sizeAddr=array, for one cycle.
- SIZEWAIT: count = min(sizeData, NArea).
  - If sizeData > NArea, sizeError=1.
  - If count==0: done pulses the next cycle, return to IDLE; outValid is never raised.
- STREAM: a read is issued in a cycle iff remaining>0 and FIFO occupancy + reads in flight < 2.
  - heapAddr = handle*NArea + idx, computed at HeapAddrWidth bits.
  - The returned word is written to the FIFO at the end of the next cycle.
  - outLast is tagged on the element with idx==count-1.
  - Enter DRAIN once the last read is issued.
- DRAIN: wait for the last element to transfer; done pulses in the cycle after it; return to IDLE.
- Latency: with start sampled at edge E0, the first outValid is high after edge E4.
  - With outReady held at 1, one element transfers per cycle after that.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- The FIFO never overflows and no element is dropped or duplicated under any outReady pattern.

Optional Feature:
ARRAY_STREAM_REVERSE_EN
- Defined: adds input port reverse (1 bit), sampled with start.
  - When reverse==1, idx runs count-1 down to 0.
  - outLast is tagged on idx 0.
- Undefined: the port is absent and streaming is always ascending.

Test Plan:
1. Handle 0, size 3, heap[0..2]=10,20,30, outReady=1 -> stream 10,20,30 on consecutive cycles; outLast only on 30; done pulses once; sizeError=0.
2. Same array, outReady toggled 1,0,0,1,... -> same three values in order, each held stable while stalled; heapRe never issues while occupancy+inflight==2.
3. Handle 5, size 0 -> outValid stays 0; done pulses 3 cycles after start; no heapRe.
4. Handle 7, size 12, heap[70..79]=1..10 -> exactly 10 elements 1..10 at heapAddr 70..79; sizeError=1 until the next start.
5. Handle 2000 -> sizeError=1, done pulses, sizeRe and heapRe stay 0; a second start during busy in any test is ignored.
6. Reset driven to 0 after 2 of 10 elements have transferred -> outValid, busy and done are 0 after that edge; a subsequent start on handle 0 streams correctly from index 0.

Source files
------------

// File: rtl/heap_array_streamer.sv
// heap_array_streamer: looks up an array's size, then streams its heap elements through a 2-entry FIFO.
// Latency: start sampled at edge E0 -> first outValid after E4; one element per cycle while outReady=1.
// Backpressure: outReady low holds the FIFO head; heap reads are credit-gated so the FIFO never overflows.
// Optional feature macro: ARRAY_STREAM_REVERSE_EN (adds the 'reverse' input for descending streaming).

// heap_stream_fifo: generic small FIFO with registered storage and an occupancy output for credit tracking.
// Latency: a word written at an edge is visible at the head right after that edge.
// Backpressure: head held while rd_rdy is low; producer must respect level (writes when full and not popping are dropped).
module heap_stream_fifo #(
  parameter int Width      = 8,
  parameter int Depth      = 2,
  parameter int LevelWidth = $clog2(Depth + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_vld,
  input  logic [Width-1:0]      wr_dat,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [Width-1:0]      rd_dat,
  output logic [LevelWidth-1:0] level
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop    = rd_vld && rd_rdy;
  assign push   = wr_vld && ((level < LevelWidth'(Depth)) || pop);
  assign rd_vld = (level != '0);
  assign rd_dat = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop in the same cycle leave the level unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      level <= level + LevelWidth'(push) - LevelWidth'(pop);
    end
  end
endmodule

// heap_array_streamer: top level; size lookup FSM plus credit-gated heap reader feeding the output FIFO.
// Latency: E0 start -> sizeRe in next cycle -> first heapRe two cycles later -> first outValid after E4.
// Backpressure: a heap read issues only when the FIFO is guaranteed a free slot when its data returns.
module heap_array_streamer #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 10,
  parameter int NArrays            = 2000,
  parameter int NHeap              = 10000,
  parameter int HeapAddrWidth      = 14
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MemoryElementWidth-1:0] array,
`ifdef ARRAY_STREAM_REVERSE_EN
  input  logic                          reverse,
`endif
  output logic                          sizeRe,
  output logic [MemoryElementWidth-1:0] sizeAddr,
  input  logic [MemoryElementWidth-1:0] sizeData,
  output logic                          heapRe,
  output logic [HeapAddrWidth-1:0]      heapAddr,
  input  logic [MemoryElementWidth-1:0] heapData,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [MemoryElementWidth-1:0] outData,
  output logic                          outLast,
  output logic                          busy,
  output logic                          done,
  output logic                          sizeError
);
  localparam int MW = MemoryElementWidth;
  // A heap too deep for the address width cannot be streamed safely, so every request is refused.
  localparam bit HeapFits = ((2 ** HeapAddrWidth) >= NHeap);

  typedef enum logic [2:0] {IDLE, SIZE, SIZEWAIT, STREAM, DRAIN} state_t;

  state_t             state;
  logic [HeapAddrWidth-1:0] base;
  logic [MW-1:0]      idx;
  logic [MW-1:0]      remaining;
  logic               inflight;
  logic               inflight_last;
  logic [1:0]         level;
  logic               pop;
  logic               issue;
  logic [2:0]         pending;
  logic               size_over;
  logic [MW-1:0]      size_clamped;
  logic               bad_handle;
  logic               rev;

`ifdef ARRAY_STREAM_REVERSE_EN
  logic rev_q;
  assign rev = rev_q;
  // Direction is captured with the request and held for its whole lifetime.
  always_ff @(posedge clock) begin
    if (!reset) rev_q <= 1'b0;
    else if (state == IDLE && start) rev_q <= reverse;
  end
`else
  assign rev = 1'b0;
`endif

  assign busy         = (state != IDLE);
  assign pop          = outValid && outReady;
  assign size_over    = (sizeData > MW'(NArea));
  assign size_clamped = size_over ? MW'(NArea) : sizeData;
  assign bad_handle   = (array >= MW'(NArrays)) || !HeapFits;
  assign heapRe       = issue;
  assign heapAddr     = base + HeapAddrWidth'(idx);

  // Credit check: entries held plus the word returning this cycle, less a slot freed by this cycle's pop.
  always_comb begin
    pending = 3'(level) + 3'(inflight) - 3'(pop);
    issue   = (state == STREAM) && (remaining != '0) && (pending < 3'd2);
  end

  // Request FSM with registered size-port outputs, done pulse, sticky error and read bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      sizeRe        <= 1'b0;
      sizeAddr      <= '0;
      base          <= '0;
      idx           <= '0;
      remaining     <= '0;
      done          <= 1'b0;
      sizeError     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done          <= 1'b0;
      sizeRe        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == MW'(1));
      case (state)
        IDLE: begin
          if (start) begin
            sizeAddr  <= array;
            base      <= HeapAddrWidth'(array) * HeapAddrWidth'(NArea);
            sizeError <= bad_handle;
            if (bad_handle) begin
              done <= 1'b1;
            end else begin
              sizeRe <= 1'b1;
              state  <= SIZE;
            end
          end
        end
        SIZE: state <= SIZEWAIT;
        SIZEWAIT: begin
          remaining <= size_clamped;
          idx       <= rev ? (size_clamped - MW'(1)) : '0;
          if (size_over) sizeError <= 1'b1;
          if (size_clamped == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (issue) begin
            remaining <= remaining - MW'(1);
            idx       <= rev ? (idx - MW'(1)) : (idx + MW'(1));
            if (remaining == MW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && outLast) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  heap_stream_fifo #(
    .Width (MW + 1),
    .Depth (2)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_vld (inflight),
    .wr_dat ({inflight_last, heapData}),
    .rd_vld (outValid),
    .rd_rdy (outReady),
    .rd_dat ({outLast, outData}),
    .level  (level)
  );
endmodule

// File: tb/tb_heap_array_streamer.sv
// Directed bench for heap_array_streamer: RAM models, a negedge monitor, and one task per scenario.
module tb_heap_array_streamer;
  localparam int MW = 12;
  localparam int NAREA = 10;
  localparam int NARR = 2000;
  localparam int NHEAP = 10000;
  localparam int HAW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] array = '0;
  logic          reverse = 1'b0;
  logic          sizeRe;
  logic [MW-1:0] sizeAddr;
  logic [MW-1:0] sizeData = '0;
  logic          heapRe;
  logic [HAW-1:0] heapAddr;
  logic [MW-1:0] heapData = '0;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [MW-1:0] outData;
  logic          outLast;
  logic          busy;
  logic          done;
  logic          sizeError;

  heap_array_streamer dut (
    .clock(clock), .reset(reset), .start(start), .array(array),
`ifdef ARRAY_STREAM_REVERSE_EN
    .reverse(reverse),
`endif
    .sizeRe(sizeRe), .sizeAddr(sizeAddr), .sizeData(sizeData),
    .heapRe(heapRe), .heapAddr(heapAddr), .heapData(heapData),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast),
    .busy(busy), .done(done), .sizeError(sizeError)
  );

  always #5 clock = ~clock;

  logic [MW-1:0] sizes_mem [NARR];
  logic [MW-1:0] heap_mem [NHEAP];

  // Synchronous-read RAM models: data valid the cycle after the read enable.
  always @(posedge clock) begin
    if (sizeRe) sizeData <= (int'(sizeAddr) < NARR) ? sizes_mem[sizeAddr] : '0;
    if (heapRe) heapData <= (int'(heapAddr) < NHEAP) ? heap_mem[heapAddr] : '0;
  end

  int cyc_n = 0;
  always @(posedge clock) cyc_n++;

  int n_cmp = 0;
  int n_bad = 0;
  int k0;

  logic [MW-1:0] got_dat[$];
  logic          got_last[$];
  int            got_cyc[$];
  int            addr_q[$];
  int done_cnt, done_cyc, sizere_cnt, heapre_cnt, ov_cnt, busy_cnt, stall_viol, credit_viol;
  int m_occ = 0, m_inf = 0, pop_i;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [MW-1:0] prev_dat = '0;

  // Mid-cycle observer: records transfers and events, and keeps its own FIFO occupancy model.
  always @(negedge clock) begin
    if (!reset) begin
      m_occ = 0; m_inf = 0; prev_stall = 1'b0;
    end else begin
      pop_i = (outValid && outReady) ? 1 : 0;
      if (prev_stall && (!outValid || outData !== prev_dat || outLast !== prev_last)) stall_viol++;
      prev_stall = outValid && !outReady;
      prev_dat = outData;
      prev_last = outLast;
      if (outValid !== (m_occ != 0)) credit_viol++;
      if (heapRe && (m_occ + m_inf - pop_i >= 2)) credit_viol++;
      m_occ = m_occ + m_inf - pop_i;
      m_inf = heapRe ? 1 : 0;
      if (pop_i == 1) begin
        got_dat.push_back(outData); got_last.push_back(outLast); got_cyc.push_back(cyc_n);
      end
      if (outValid) ov_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc_n; end
      if (sizeRe) sizere_cnt++;
      if (heapRe) begin heapre_cnt++; addr_q.push_back(int'(heapAddr)); end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_obs();
    got_dat.delete(); got_last.delete(); got_cyc.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; sizere_cnt = 0; heapre_cnt = 0;
    ov_cnt = 0; busy_cnt = 0; stall_viol = 0; credit_viol = 0;
  endtask

  task automatic start_req(input logic [MW-1:0] h, input logic rev);
    start = 1'b1; array = h; reverse = rev;
    cyc();
    start = 1'b0; reverse = 1'b0;
    k0 = cyc_n;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run(3);
    n_cmp++;
    if ({sizeRe, heapRe, outValid, outLast, busy, done, sizeError} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000000", {sizeRe, heapRe, outValid, outLast, busy, done, sizeError});
    end
    n_cmp++;
    if (outData !== '0) begin n_bad++; $display("FAIL reset_outData: got %0d expected 0", outData); end
    n_cmp++;
    if (sizeAddr !== '0) begin n_bad++; $display("FAIL reset_sizeAddr: got %0d expected 0", sizeAddr); end
    n_cmp++;
    if (heapAddr !== '0) begin n_bad++; $display("FAIL reset_heapAddr: got %0d expected 0", heapAddr); end
    reset = 1'b1;
    run(2);
  endtask

  task automatic test_basic();
    clear_obs();
    outReady = 1'b1;
    start_req(12'd0, 1'b0);
    run(12);
    n_cmp++;
    if (got_dat.size() !== 3) begin n_bad++; $display("FAIL basic_count: got %0d expected 3", got_dat.size()); end
    else begin
      n_cmp++;
      if ({got_dat[0], got_dat[1], got_dat[2]} !== {12'd10, 12'd20, 12'd30}) begin
        n_bad++; $display("FAIL basic_data: got %0d,%0d,%0d expected 10,20,30", got_dat[0], got_dat[1], got_dat[2]);
      end
      n_cmp++;
      if ({got_last[0], got_last[1], got_last[2]} !== 3'b001) begin
        n_bad++; $display("FAIL basic_last: got %b expected 001", {got_last[0], got_last[1], got_last[2]});
      end
      n_cmp++;
      if (got_cyc[0] !== k0 + 4 || got_cyc[2] !== k0 + 6) begin
        n_bad++; $display("FAIL basic_timing: got first %0d last %0d expected %0d %0d", got_cyc[0] - k0, got_cyc[2] - k0, 4, 6);
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== k0 + 7) begin
      n_bad++; $display("FAIL basic_done: got count %0d at +%0d expected 1 at +7", done_cnt, done_cyc - k0);
    end
    n_cmp++;
    if (sizeError !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_end_state: got err %b busy %b expected 0 0", sizeError, busy);
    end
  endtask

  task automatic test_stall();
    clear_obs();
    start_req(12'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      outReady = (i % 3 == 0);
      start = (i == 6);
      array = 12'd5;
      cyc();
    end
    start = 1'b0;
    outReady = 1'b1;
    n_cmp++;
    if (got_dat.size() !== 3) begin n_bad++; $display("FAIL stall_count: got %0d expected 3", got_dat.size()); end
    else begin
      n_cmp++;
      if ({got_dat[0], got_dat[1], got_dat[2], got_last[0], got_last[1], got_last[2]} !== {12'd10, 12'd20, 12'd30, 3'b001}) begin
        n_bad++; $display("FAIL stall_data: got %0d,%0d,%0d last %b expected 10,20,30 last 001",
                          got_dat[0], got_dat[1], got_dat[2], {got_last[0], got_last[1], got_last[2]});
      end
    end
    n_cmp++;
    if (stall_viol !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable stalls expected 0", stall_viol); end
    n_cmp++;
    if (credit_viol !== 0) begin n_bad++; $display("FAIL stall_credit: got %0d credit violations expected 0", credit_viol); end
    n_cmp++;
    if (done_cnt !== 1 || sizere_cnt !== 1) begin
      n_bad++; $display("FAIL stall_busy_start: got done %0d sizeRe %0d expected 1 1", done_cnt, sizere_cnt);
    end
  endtask

  task automatic test_zero_size();
    clear_obs();
    start_req(12'd5, 1'b0);
    run(8);
    n_cmp++;
    if (ov_cnt !== 0 || heapre_cnt !== 0) begin
      n_bad++; $display("FAIL zero_no_data: got outValid %0d heapRe %0d expected 0 0", ov_cnt, heapre_cnt);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== k0 + 2) begin
      n_bad++; $display("FAIL zero_done: got count %0d at +%0d expected 1 at +2", done_cnt, done_cyc - k0);
    end
    n_cmp++;
    if (sizere_cnt !== 1 || sizeError !== 1'b0) begin
      n_bad++; $display("FAIL zero_size_read: got sizeRe %0d err %b expected 1 0", sizere_cnt, sizeError);
    end
  endtask

  task automatic test_clamp();
    int bad_dat, bad_addr;
    clear_obs();
    start_req(12'd7, 1'b0);
    run(25);
    bad_dat = 0; bad_addr = 0;
    foreach (got_dat[i]) if (got_dat[i] !== MW'(i + 1) || got_last[i] !== (i == 9)) bad_dat++;
    foreach (addr_q[i]) if (addr_q[i] !== 70 + i) bad_addr++;
    n_cmp++;
    if (got_dat.size() !== 10 || bad_dat !== 0) begin
      n_bad++; $display("FAIL clamp_data: got %0d elements %0d wrong expected 10 elements 0 wrong", got_dat.size(), bad_dat);
    end
    n_cmp++;
    if (heapre_cnt !== 10 || bad_addr !== 0) begin
      n_bad++; $display("FAIL clamp_addr: got %0d reads %0d wrong expected 10 reads 0 wrong", heapre_cnt, bad_addr);
    end
    n_cmp++;
    if (sizeError !== 1'b1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL clamp_error: got err %b done %0d expected 1 1", sizeError, done_cnt);
    end
    clear_obs();
    start_req(12'd0, 1'b0);
    n_cmp++;
    if (sizeError !== 1'b0) begin n_bad++; $display("FAIL clamp_error_clear: got %b expected 0", sizeError); end
    run(12);
    n_cmp++;
    if (got_dat.size() !== 3 || done_cnt !== 1) begin
      n_bad++; $display("FAIL clamp_followup: got %0d elements done %0d expected 3 1", got_dat.size(), done_cnt);
    end
  endtask

  task automatic test_bad_handle();
    logic [MW-1:0] handles [2];
    handles[0] = 12'd2000;
    handles[1] = 12'd4095;
    for (int t = 0; t < 2; t++) begin
      clear_obs();
      start_req(handles[t], 1'b0);
      n_cmp++;
      if (sizeError !== 1'b1) begin n_bad++; $display("FAIL bad_handle_err_%0d: got %b expected 1", handles[t], sizeError); end
      run(6);
      n_cmp++;
      if (done_cnt !== 1 || done_cyc !== k0) begin
        n_bad++; $display("FAIL bad_handle_done_%0d: got count %0d at +%0d expected 1 at +0", handles[t], done_cnt, done_cyc - k0);
      end
      n_cmp++;
      if (sizere_cnt !== 0 || heapre_cnt !== 0 || busy_cnt !== 0) begin
        n_bad++; $display("FAIL bad_handle_quiet_%0d: got sizeRe %0d heapRe %0d busy %0d expected 0 0 0",
                          handles[t], sizere_cnt, heapre_cnt, busy_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    clear_obs();
    outReady = 1'b1;
    start_req(12'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (got_dat.size() >= 2) break;
    end
    reset = 1'b0;
    outReady = 1'b0;
    cyc();
    n_cmp++;
    if ({outValid, busy, done} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_outputs: got valid %b busy %b done %b expected 0 0 0", outValid, busy, done);
    end
    n_cmp++;
    if (got_dat.size() !== 2 || got_dat[1] !== 12'd102) begin
      n_bad++; $display("FAIL midreset_transferred: got %0d elements expected 2 ending 102", got_dat.size());
    end
    reset = 1'b1;
    outReady = 1'b1;
    run(5);
    n_cmp++;
    if (done_cnt !== 0 || ov_cnt !== 2) begin
      n_bad++; $display("FAIL midreset_no_done: got done %0d valid cycles %0d expected 0 2", done_cnt, ov_cnt);
    end
    clear_obs();
    start_req(12'd0, 1'b0);
    run(12);
    n_cmp++;
    if (got_dat.size() !== 3 || got_dat[0] !== 12'd10 || got_dat[2] !== 12'd30 || done_cnt !== 1) begin
      n_bad++; $display("FAIL midreset_restart: got %0d elements done %0d expected 3 elements 10..30 done 1", got_dat.size(), done_cnt);
    end
  endtask

`ifdef ARRAY_STREAM_REVERSE_EN
  task automatic test_reverse();
    clear_obs();
    outReady = 1'b1;
    start_req(12'd0, 1'b1);
    run(12);
    n_cmp++;
    if (got_dat.size() !== 3) begin n_bad++; $display("FAIL reverse_count: got %0d expected 3", got_dat.size()); end
    else begin
      n_cmp++;
      if ({got_dat[0], got_dat[1], got_dat[2], got_last[0], got_last[1], got_last[2]} !== {12'd30, 12'd20, 12'd10, 3'b001}) begin
        n_bad++; $display("FAIL reverse_data: got %0d,%0d,%0d expected 30,20,10 last on 10", got_dat[0], got_dat[1], got_dat[2]);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NARR; i++) sizes_mem[i] = '0;
    for (int i = 0; i < NHEAP; i++) heap_mem[i] = '0;
    sizes_mem[0] = 12'd3;
    heap_mem[0] = 12'd10; heap_mem[1] = 12'd20; heap_mem[2] = 12'd30;
    sizes_mem[1] = 12'd10;
    for (int i = 0; i < 10; i++) heap_mem[10 + i] = MW'(101 + i);
    sizes_mem[5] = 12'd0;
    sizes_mem[7] = 12'd12;
    for (int i = 0; i < 10; i++) heap_mem[70 + i] = MW'(i + 1);
    heap_mem[80] = 12'd99; heap_mem[81] = 12'd98;
    clear_obs();

    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_clamp();
    test_bad_handle();
    test_reset_mid_stream();
`ifdef ARRAY_STREAM_REVERSE_EN
    test_reverse();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
